// File: rtl/ram_ctrl.sv
// Single-port RAM with valid/ready requests, byte-enabled writes, RD_LAT-stage read pipeline and a
// hardware clear sequence after reset or clr_req. Optional per-byte even parity under `RAM_PARITY_EN`.
module ram_ctrl #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_rw,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  input  logic                clr_req,
  input  logic                perr_inj,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_perr,
  output logic                init_done
);

  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] clr_cnt, clr_cnt_nxt;
  logic              acc_rd;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [NB-1:0]     mem_be;
  logic              rd_perr;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    req_ready   = 1'b0;
    init_done   = 1'b0;
    acc_rd      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = req_addr;
    mem_wdata   = req_wdata;
    mem_be      = req_be;
    case (state)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_addr  = clr_cnt;
        mem_wdata = '0;
        mem_be    = '1;
        // Counter parks at all-ones; the next clear reloads it to zero.
        if (&clr_cnt) state_nxt = RUN;
        else          clr_cnt_nxt = clr_cnt + ADDR_W'(1);
      end
      RUN: begin
        req_ready = 1'b1;
        init_done = 1'b1;
        if (req_valid) begin
          if (req_rw) acc_rd = 1'b1;
          else        mem_we = 1'b1;
        end
        if (clr_req) begin
          state_nxt   = CLEAR;
          clr_cnt_nxt = '0;
        end
      end
      default: state_nxt = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < NB; i++) begin
        if (mem_be[i]) mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
  end

`ifdef RAM_PARITY_EN
  logic [NB-1:0] par [DEPTH];
  logic          mem_inj;

  assign mem_inj = (state == RUN) && perr_inj;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < NB; i++) begin
        if (mem_be[i]) par[mem_addr][i] <= (^mem_wdata[8*i +: 8]) ^ mem_inj;
      end
    end
  end

  always_comb begin
    rd_perr = 1'b0;
    for (int i = 0; i < NB; i++) begin
      if ((^mem[req_addr][8*i +: 8]) != par[req_addr][i]) rd_perr = 1'b1;
    end
  end
`else
  logic unused_perr_inj;
  assign unused_perr_inj = perr_inj;
  assign rd_perr         = 1'b0;
`endif

  // Stage 0 is the array read; later stages only advance when their input is valid,
  // so the last stage holds the previous response between pulses.
  logic [RD_LAT-1:0] pv;
  logic [RD_LAT-1:0] pp;
  logic [DATA_W-1:0] pd [RD_LAT];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pv <= '0;
      pp <= '0;
      for (int i = 0; i < RD_LAT; i++) pd[i] <= '0;
    end else begin
      pv[0] <= acc_rd;
      if (acc_rd) begin
        pd[0] <= mem[req_addr];
        pp[0] <= rd_perr;
      end
      for (int i = 1; i < RD_LAT; i++) begin
        pv[i] <= pv[i-1];
        if (pv[i-1]) begin
          pd[i] <= pd[i-1];
          pp[i] <= pp[i-1];
        end
      end
    end
  end

  assign rsp_valid = pv[RD_LAT-1];
  assign rsp_rdata = pd[RD_LAT-1];
  assign rsp_perr  = pv[RD_LAT-1] & pp[RD_LAT-1];

endmodule

// File: doc/ram_ctrl.md
# ram_ctrl

Parametrised single-port synchronous RAM with a valid/ready request interface, byte-enabled writes and a configurable-latency pipelined read path. After reset, or on request, it runs a hardware clear sequence that zeroes every word. It is the next-generation data/program store for the core: a drop-in home for any memory client that needs pipelined reads, partial-word writes and a known post-reset memory state.

## Interface
- ADDR_W, 16, address width; depth is 2^ADDR_W words.
- DATA_W, 32, word width; must be a multiple of 8.
- RD_LAT, 1, read latency in cycles; legal range 1..4.

- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_rw  in  1  1 = read, 0 = write.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  write data.
- req_be  in  DATA_W/8  byte enables for writes; bit i covers bits [8i+7:8i]; ignored on reads.
- clr_req  in  1  one-cycle pulse that restarts the clear sequence.
- perr_inj  in  1  parity fault injection on writes; functional only with RAM_PARITY_EN.
- rsp_valid  out  1  read data valid, one-cycle pulse per read.
- rsp_rdata  out  DATA_W  read data.
- rsp_perr  out  1  parity error on the current response.
- init_done  out  1  clear sequence complete.

## Operation
- States: CLEAR and RUN.
- Reset values while rst_n=0 at an edge:
  - state=CLEAR, clear counter=0, req_ready=0, init_done=0.
  - rsp_valid=0, rsp_rdata=0, rsp_perr=0.
  - Read pipeline flushed.
  - Memory contents are not reset; they are rewritten by CLEAR.
- CLEAR:
  - Writes 0 (with correct parity) to address = counter, one word per cycle, counter 0 → 2^ADDR_W−1.
  - After the write to the last address, go to RUN; init_done=1 and req_ready=1 from the next cycle.
  - The counter is ADDR_W bits; terminal detection is all-ones, no wrap past it.
  - req_valid is ignored in CLEAR. clr_req in CLEAR has no effect.
- RUN:
  - req_ready=1. A request is accepted when req_valid & req_ready at an edge.
  - Write: each byte with req_be[i]=1 is updated at the accepting edge; other bytes are untouched. req_be=0 is a legal no-op.
  - Read: the array is read at the accepting edge. Data passes through RD_LAT−1 further register stages to rsp_rdata. Throughput is one read per cycle.
  - No response backpressure: every accepted read produces exactly one rsp_valid pulse, in request order.
  - rsp_rdata holds the last response value while rsp_valid=0.
- Read-after-write: a write accepted at edge N is visible to a read accepted at edge N+1 or later. No same-cycle collision is possible on a single port.
- clr_req in RUN:
  - A request presented in the same cycle is still accepted.
  - From the next cycle: state=CLEAR, counter=0, req_ready=0, init_done=0.
  - In-flight reads drain normally, returning their pre-clear data.
- rst_n low mid-operation: in-flight reads are dropped (no rsp_valid), and CLEAR restarts from 0.

## Timing
- Read accepted in cycle k: rsp_valid=1 with data in cycle k+RD_LAT.
- Write: one cycle, no response.
- CLEAR duration is 2^ADDR_W cycles. init_done rises in cycle 2^ADDR_W after the first CLEAR cycle.
- Back-to-back reads produce back-to-back rsp_valid pulses.

## Configuration
- RAM_PARITY_EN defined:
  - Each byte is stored with an even-parity bit.
  - On a read, parity is recomputed; rsp_perr=1 with rsp_valid if any byte mismatches.
  - A write with perr_inj=1 stores inverted parity for every enabled byte.
- RAM_PARITY_EN undefined:
  - No parity storage.
  - rsp_perr is tied 0 and perr_inj is ignored.
- All ports exist in both builds.

## Test plan
- Clear after reset (ADDR_W=4, RD_LAT=2): hold rst_n=0 for 2 cycles, then release.
  - init_done rises exactly 16 cycles after release.
  - Reads of all 16 addresses return 0x00000000.
- Byte-enable write: write 0xAABBCCDD with be=1111 to addr 3, then 0x11223344 with be=0101, then read addr 3.
  - Returns 0xAA22CC44 in cycle k+RD_LAT.
- Pipelined reads (RD_LAT=3): four consecutive reads of addrs 0..3 preloaded with 0..3.
  - Four consecutive rsp_valid pulses return 0,1,2,3.
  - The first pulse arrives 3 cycles after the first accept.
- clr_req mid-stream: a read of addr 5 (holding 0x55) is accepted with clr_req in the same cycle.
  - Response returns 0x55.
  - req_ready=0 for 16 cycles.
  - A subsequent read of addr 5 returns 0.
- Reset mid-read: assert rst_n=0 one cycle after a read accept.
  - No rsp_valid appears for that read.
  - The clear sequence restarts from address 0.
- Parity (RAM_PARITY_EN): write addr 7 with perr_inj=1, then read it.
  - rsp_perr=1 with rsp_valid.
  - A normal rewrite of addr 7 followed by a read gives rsp_perr=0.
  - Without the macro, the same stimulus gives rsp_perr=0.
